reflector_cfg: RTL and testbench

Programmable Enigma reflector (UKW-D style rewirable reflector) for the N-letter datapath. It replaces the fixed combinational reflector and applies a stored involutive pairing to the one-hot letter bus with one cycle of registered latency. A pair-load handshake fills a shadow table, which a checker scans. The shadow table is committed atomically only if it is a valid fixed-point-free involution. Until a valid load commits, the block reflects with the 1941 UKW pairing.

---
 rtl/reflector_cfg.sv | 166 ++++++++++++++++
 tb/tb_reflector_cfg.sv | 373 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reflector_cfg.sv
// Rewirable Enigma reflector: registered one-hot letter permutation through an
// active pairing table, reloaded through a pair handshake with a verify/commit pass.
module reflector_cfg #(
    parameter int N  = 26,
    parameter int IW = $clog2(N)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    input  logic [N-1:0]  in,
    output logic          out_valid,
    output logic [N-1:0]  out,
    input  logic          cfg_start,
    input  logic          cfg_valid,
    input  logic [IW-1:0] cfg_a,
    input  logic [IW-1:0] cfg_b,
    output logic          cfg_ready,
    output logic          cfg_busy,
    output logic          cfg_done,
    output logic          cfg_error
);

    localparam int NP = N / 2;
    localparam int CW = $clog2(NP + 1);

    // 1941 UKW partner of each letter (A..Z)
    localparam int UKW [26] = '{16, 24, 7, 14, 6, 13, 4, 2, 21, 15, 20, 25, 19,
                                5, 3, 9, 0, 23, 22, 12, 10, 8, 18, 17, 1, 11};

    typedef enum logic [1:0] {IDLE, LOADING, VERIFY, COMMIT} state_t;

    state_t        state, state_nx;
    logic [IW-1:0] act    [N];
    logic [IW-1:0] shadow [N];
    logic [N-1:0]  written;
    logic [CW-1:0] pair_cnt;
    logic [IW-1:0] scan;
    logic          err;
    logic [N-1:0]  perm;

    logic          accept, clear_load, pair_bad, scan_bad;
    logic          a_oob, b_oob;
    logic [IW-1:0] scan_partner, scan_back;

    function automatic logic [IW-1:0] default_partner(input int i);
        if (N == 26 && i < 26)
            return IW'(UKW[i]);
        return IW'(i ^ 1);
    endfunction

    // Lookup path: out[act[i]] = in[i], so a non-one-hot bus is simply permuted.
    always_comb begin
        perm = '0;
        for (int i = 0; i < N; i++)
            perm[act[i]] = in[i];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out       <= '0;
            out_valid <= 1'b0;
        end else begin
            out       <= perm;
            out_valid <= in_valid;
        end
    end

    // Load-pair and verify-scan checks
    always_comb begin
        a_oob        = int'(cfg_a) >= N;
        b_oob        = int'(cfg_b) >= N;
        pair_bad     = a_oob || b_oob || (cfg_a == cfg_b) ||
                       (!a_oob && written[cfg_a]) || (!b_oob && written[cfg_b]);
        scan_partner = shadow[scan];
        scan_back    = (int'(scan_partner) < N) ? shadow[scan_partner] : scan;
        scan_bad     = !written[scan] || (scan_partner == scan) ||
                       (int'(scan_partner) >= N) || (scan_back != scan);
    end

    assign accept     = cfg_valid && (state == LOADING) && !cfg_start;
    assign clear_load = cfg_start && (state == IDLE || state == LOADING);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nx;
    end

    // NOTE: every variable written here gets a default first, so no latch is inferred.
    always_comb begin
        state_nx  = state;
        cfg_ready = 1'b0;
        cfg_busy  = 1'b0;
        cfg_done  = 1'b0;
        cfg_error = 1'b0;
        case (state)
            IDLE: begin
                if (cfg_start)
                    state_nx = LOADING;
            end
            LOADING: begin
                cfg_ready = 1'b1;
                cfg_busy  = 1'b1;
                if (!cfg_start && accept && pair_cnt == CW'(NP - 1))
                    state_nx = VERIFY;
            end
            VERIFY: begin
                cfg_busy = 1'b1;
                if (scan == IW'(N - 1))
                    state_nx = COMMIT;
            end
            COMMIT: begin
                cfg_done  = 1'b1;
                cfg_error = err;
                state_nx  = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // NOTE: the tables are small register files, so they are reset like any other
    // state; that is what lets reset restore the default pairing in one step.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N; i++) begin
                act[i]    <= default_partner(i);
                shadow[i] <= '0;
            end
            written  <= '0;
            pair_cnt <= '0;
            scan     <= '0;
            err      <= 1'b0;
        end else begin
            if (clear_load) begin
                for (int i = 0; i < N; i++)
                    shadow[i] <= '0;
                written  <= '0;
                pair_cnt <= '0;
                scan     <= '0;
                err      <= 1'b0;
            end else if (accept) begin
                pair_cnt <= pair_cnt + CW'(1);
                if (pair_bad) begin
                    err <= 1'b1;
                end else begin
                    shadow[cfg_a]  <= cfg_b;
                    shadow[cfg_b]  <= cfg_a;
                    written[cfg_a] <= 1'b1;
                    written[cfg_b] <= 1'b1;
                end
            end else if (state == VERIFY) begin
                scan <= scan + IW'(1);
                if (scan_bad)
                    err <= 1'b1;
            end

            // Atomic swap: lookups on this edge still see the old table.
            if (state == COMMIT && !err) begin
                for (int i = 0; i < N; i++)
                    act[i] <= shadow[i];
            end
        end
    end

endmodule

// File: tb/tb_reflector_cfg.sv
// Directed bench for reflector_cfg: default pairing, loads, rejects, commit timing,
// restart and reset mid-load.
module tb_reflector_cfg;

    localparam int N  = 26;
    localparam int IW = 5;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          in_valid = 1'b0;
    logic [N-1:0]  din = '0;
    logic          cfg_start = 1'b0;
    logic          cfg_valid = 1'b0;
    logic [IW-1:0] cfg_a = '0;
    logic [IW-1:0] cfg_b = '0;
    logic          out_valid;
    logic [N-1:0]  dout;
    logic          cfg_ready, cfg_busy, cfg_done, cfg_error;

    int total = 0;
    int bad   = 0;
    int edges = 0;
    int dflt [N];
    logic [IW-1:0] pa [13];
    logic [IW-1:0] pb [13];

    reflector_cfg #(.N(N), .IW(IW)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in(din),
        .out_valid(out_valid), .out(dout), .cfg_start(cfg_start),
        .cfg_valid(cfg_valid), .cfg_a(cfg_a), .cfg_b(cfg_b),
        .cfg_ready(cfg_ready), .cfg_busy(cfg_busy), .cfg_done(cfg_done),
        .cfg_error(cfg_error)
    );

    always #5 clk = ~clk;

    function automatic logic [N-1:0] onehot(input int i);
        logic [N-1:0] v;
        v = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        edges++;
    endtask

    task automatic lookup(input int i, output logic [N-1:0] o, output logic v);
        din      = onehot(i);
        in_valid = 1'b1;
        tick();
        o = dout;
        v = out_valid;
    endtask

    task automatic start_load();
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        edges = 0;
    endtask

    task automatic feed(input int n);
        for (int k = 0; k < n; k++) begin
            cfg_valid = 1'b1;
            cfg_a     = pa[k];
            cfg_b     = pb[k];
            tick();
        end
        cfg_valid = 1'b0;
        cfg_a     = '0;
        cfg_b     = '0;
    endtask

    task automatic wait_done(output int cyc, output logic e);
        int guard;
        guard = 0;
        while (!cfg_done && guard < 200) begin
            tick();
            guard++;
        end
        cyc = edges;
        e   = cfg_error;
        total++;
        if (!cfg_done) begin
            bad++;
            $display("FAIL done_timeout: cfg_done never rose within %0d cycles", guard);
        end
    endtask

    task automatic test_reset();
        in_valid = 1'b1;
        din      = onehot(0);
        tick();
        tick();
        total++;
        if ({out_valid, dout, cfg_ready, cfg_busy, cfg_done, cfg_error} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: got ov=%b out=%h rdy=%b busy=%b done=%b err=%b, want all 0",
                     out_valid, dout, cfg_ready, cfg_busy, cfg_done, cfg_error);
        end
        reset    = 1'b0;
        in_valid = 1'b0;
        din      = '0;
        tick();
    endtask

    task automatic test_default_lookup();
        logic [N-1:0] o;
        logic         v;
        for (int i = 0; i < N; i++) begin
            lookup(i, o, v);
            total++;
            if (o !== onehot(dflt[i]) || v !== 1'b1) begin
                bad++;
                $display("FAIL default_map[%0d]: got out=%h ov=%b, want out=%h ov=1",
                         i, o, v, onehot(dflt[i]));
            end
        end
        in_valid = 1'b0;
        din      = '0;
        tick();
        total++;
        if (dout !== '0 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL idle_lookup: got out=%h ov=%b, want 0 0", dout, out_valid);
        end
        // Non-one-hot input: A|C -> Q|H
        din = onehot(0) | onehot(2);
        tick();
        total++;
        if (dout !== (onehot(16) | onehot(7))) begin
            bad++;
            $display("FAIL multi_hot: got %h, want %h", dout, onehot(16) | onehot(7));
        end
        din = '0;
    endtask

    task automatic test_reused_letter();
        int cyc;
        logic e;
        logic [N-1:0] o;
        logic v;
        pa[0] = 0; pb[0] = 1;
        pa[1] = 0; pb[1] = 2;
        for (int k = 2; k < 13; k++) begin
            pa[k] = IW'(2 * k);
            pb[k] = IW'(2 * k + 1);
        end
        start_load();
        feed(13);
        wait_done(cyc, e);
        total++;
        if (e !== 1'b1) begin
            bad++;
            $display("FAIL reused_error: got cfg_error=%b, want 1", e);
        end
        tick();
        lookup(0, o, v);
        total++;
        if (o !== onehot(16)) begin
            bad++;
            $display("FAIL reused_keeps_table: A maps to %h, want %h", o, onehot(16));
        end
        in_valid = 1'b0;
    endtask

    task automatic test_bad_pairs();
        int cyc;
        logic e;
        for (int t = 0; t < 2; t++) begin
            for (int k = 0; k < 13; k++) begin
                pa[k] = IW'(2 * k);
                pb[k] = IW'(2 * k + 1);
            end
            if (t == 0) begin
                pa[1] = 3; pb[1] = 3;
            end else begin
                pa[0] = 27; pb[0] = 1;
            end
            start_load();
            feed(13);
            wait_done(cyc, e);
            total++;
            if (e !== 1'b1) begin
                bad++;
                $display("FAIL bad_pair_%0d: got cfg_error=%b, want 1", t, e);
            end
            tick();
        end
    endtask

    task automatic test_load_valid();
        int cyc;
        logic e;
        logic [N-1:0] o;
        logic v;
        for (int k = 0; k < 13; k++) begin
            pa[k] = IW'(2 * k);
            pb[k] = IW'(2 * k + 1);
        end
        start_load();
        total++;
        if (cfg_ready !== 1'b1 || cfg_busy !== 1'b1) begin
            bad++;
            $display("FAIL loading_flags: got rdy=%b busy=%b, want 1 1", cfg_ready, cfg_busy);
        end
        feed(13);
        total++;
        if (cfg_ready !== 1'b0 || cfg_busy !== 1'b1) begin
            bad++;
            $display("FAIL verify_flags: got rdy=%b busy=%b, want 0 1", cfg_ready, cfg_busy);
        end
        wait_done(cyc, e);
        total++;
        if (cyc != 39 || e !== 1'b0) begin
            bad++;
            $display("FAIL load_done: got done after %0d cycles err=%b, want 39 err=0", cyc, e);
        end
        tick();
        total++;
        if (cfg_done !== 1'b0 || cfg_busy !== 1'b0) begin
            bad++;
            $display("FAIL done_pulse: got done=%b busy=%b after commit, want 0 0", cfg_done, cfg_busy);
        end
        lookup(0, o, v);
        total++;
        if (o !== onehot(1)) begin
            bad++;
            $display("FAIL new_map_A: got %h, want %h", o, onehot(1));
        end
        lookup(25, o, v);
        total++;
        if (o !== onehot(24)) begin
            bad++;
            $display("FAIL new_map_Z: got %h, want %h", o, onehot(24));
        end
    endtask

    task automatic test_commit_boundary();
        int cyc;
        logic e;
        // Shifted pairing: A-Z, B-C, D-E, ..., X-Y
        pa[0] = 0; pb[0] = 25;
        for (int k = 1; k < 13; k++) begin
            pa[k] = IW'(2 * k - 1);
            pb[k] = IW'(2 * k);
        end
        in_valid = 1'b1;
        din      = onehot(0);
        start_load();
        feed(13);
        wait_done(cyc, e);
        tick();
        total++;
        if (dout !== onehot(1) || out_valid !== 1'b1) begin
            bad++;
            $display("FAIL commit_edge_old: got out=%h ov=%b, want %h ov=1", dout, out_valid, onehot(1));
        end
        tick();
        total++;
        if (dout !== onehot(25) || out_valid !== 1'b1) begin
            bad++;
            $display("FAIL after_commit_new: got out=%h ov=%b, want %h ov=1", dout, out_valid, onehot(25));
        end
        in_valid = 1'b0;
        din      = '0;
    endtask

    task automatic test_restart_mid_load();
        int cyc;
        logic e;
        logic [N-1:0] o;
        logic v;
        for (int k = 0; k < 13; k++) begin
            pa[k] = IW'(2 * k);
            pb[k] = IW'(2 * k + 1);
        end
        pa[0] = 5; pb[0] = 5;
        start_load();
        feed(5);
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        edges = 0;
        pa[0] = 0; pb[0] = 1;
        feed(12);
        total++;
        if (cfg_ready !== 1'b1 || cfg_busy !== 1'b1) begin
            bad++;
            $display("FAIL restart_still_loading: got rdy=%b busy=%b after 12 pairs, want 1 1",
                     cfg_ready, cfg_busy);
        end
        cfg_valid = 1'b1;
        cfg_a     = pa[12];
        cfg_b     = pb[12];
        tick();
        cfg_valid = 1'b0;
        total++;
        if (cfg_ready !== 1'b0) begin
            bad++;
            $display("FAIL restart_13th: got rdy=%b after 13th pair, want 0", cfg_ready);
        end
        wait_done(cyc, e);
        total++;
        if (e !== 1'b0) begin
            bad++;
            $display("FAIL restart_clears_err: got cfg_error=%b, want 0", e);
        end
        tick();
        lookup(0, o, v);
        total++;
        if (o !== onehot(1)) begin
            bad++;
            $display("FAIL restart_map_A: got %h, want %h", o, onehot(1));
        end
        in_valid = 1'b0;
    endtask

    task automatic test_reset_mid_verify();
        logic [N-1:0] o;
        logic v;
        for (int k = 0; k < 13; k++) begin
            pa[k] = IW'(2 * k);
            pb[k] = IW'(2 * k + 1);
        end
        start_load();
        feed(13);
        repeat (5) tick();
        reset = 1'b1;
        #1;
        total++;
        if (cfg_busy !== 1'b0 || dout !== '0) begin
            bad++;
            $display("FAIL reset_mid_verify: got busy=%b out=%h, want 0 0", cfg_busy, dout);
        end
        tick();
        reset = 1'b0;
        lookup(2, o, v);
        total++;
        if (o !== onehot(7) || cfg_busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_restores_default: C maps to %h busy=%b, want %h busy=0",
                     o, cfg_busy, onehot(7));
        end
        in_valid = 1'b0;
    endtask

    initial begin
        string s;
        s = "AQBYCHDOEGFNIVJPKULZMTRXSW";
        for (int k = 0; k < 13; k++) begin
            int a, b;
            a = int'(s[2 * k]) - 65;
            b = int'(s[2 * k + 1]) - 65;
            dflt[a] = b;
            dflt[b] = a;
        end
        test_reset();
        test_default_lookup();
        test_reused_letter();
        test_bad_pairs();
        test_load_valid();
        test_commit_boundary();
        test_restart_mid_load();
        test_reset_mid_verify();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
